// File: rtl/dmac_xfer_seq_if.sv
// Request/response bus between the DMA transfer sequencer
// and the AHB master controller beneath it.
interface dmac_xfer_seq_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic        wr_done;
    logic        hresp;

    modport master (
        output rd, wr, addr, wdata,
        input  rd_en, rdata, wr_done, hresp
    );

    modport slave (
        input  rd, wr, addr, wdata,
        output rd_en, rdata, wr_done, hresp
    );
endinterface

// File: rtl/dmac_xfer_seq.sv
// Single-channel DMA copy sequencer: read a chunk into a buffer, then write it out.
// Define DMAC_SEQ_ERR_EN to abort on hresp and raise the sticky err flag.
module dmac_xfer_seq #(
    parameter int BURST = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    dmac_xfer_seq_if.master  bus
);

    localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               err_q, err_d;
    logic               buf_we;
    logic               resp_err;
    logic               idx_last;
    logic [31:0]        buf_q [BURST];

`ifdef DMAC_SEQ_ERR_EN
    assign resp_err = bus.hresp;
`else
    wire unused_hresp = bus.hresp;
    assign resp_err = 1'b0;
`endif

    // Last buffer index of a chunk of min(BURST, r) words.
    function automatic logic [IDX_W-1:0] chunk_last(input logic [LEN_W-1:0] r);
        if (r >= LEN_W'(BURST))
            return IDX_W'(BURST - 1);
        return IDX_W'(r - 1'b1);
    endfunction

    assign idx_last = (idx_q == last_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = err_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = {src_addr[31:2], 2'b00};
                    dst_d   = {dst_addr[31:2], 2'b00};
                    rem_d   = len;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    last_d  = chunk_last(len);
                    state_d = (len == '0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.rd_en) begin
                    if (resp_err) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        buf_we = 1'b1;
                        src_d  = src_q + 32'd4;
                        if (idx_last) begin
                            idx_d   = '0;
                            state_d = WR_REQ;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (bus.wr_done) begin
                    if (resp_err) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        dst_d = dst_q + 32'd4;
                        rem_d = rem_q - 1'b1;
                        if (idx_last) begin
                            idx_d   = '0;
                            last_d  = chunk_last(rem_d);
                            state_d = (rem_d == '0) ? FIN : RD_REQ;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = WR_REQ;
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Chunk buffer holds no reset; it is only read after being filled.
    always_ff @(posedge clk) begin
        if (buf_we)
            buf_q[idx_q] <= bus.rdata;
    end

    assign bus.rd    = (state_q == RD_REQ);
    assign bus.wr    = (state_q == WR_REQ);
    assign bus.addr  = bus.rd ? src_q : (bus.wr ? dst_q : 32'd0);
    assign bus.wdata = bus.wr ? buf_q[idx_q] : 32'd0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = err_q;

endmodule

// File: tb/tb_dmac_xfer_seq.sv
// Directed bench for dmac_xfer_seq with a small AHB-side responder model.
// Read data is a fixed function of the address so writes can be predicted.
module tb_dmac_xfer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    dmac_xfer_seq_if bus ();

    dmac_xfer_seq #(.BURST(4), .LEN_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    logic [31:0] rd_a [$];
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];
    logic [31:0] ops;
    int          nops;
    int          viol;
    int          ndone;
    int          wcnt;
    int          err_wr   = 0;
    bit          rand_dly = 0;

    // Bus monitor: logs requests and flags protocol violations.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rd && bus.wr) viol++;
            if ((bus.rd || bus.wr) && prev_req) viol++;
            if (!bus.rd && !bus.wr && (bus.addr != 0 || bus.wdata != 0))
                viol++;
            prev_req = bus.rd || bus.wr;
            if (bus.rd) begin
                rd_a.push_back(bus.addr);
                ops = {ops[30:0], 1'b0};
                nops++;
            end
            if (bus.wr) begin
                wr_a.push_back(bus.addr);
                wr_d.push_back(bus.wdata);
                ops = {ops[30:0], 1'b1};
                nops++;
            end
            if (done) ndone++;
        end
    end

    // Responder: answers one request at a time after 0..5 extra cycles.
    initial begin
        logic        is_wr;
        logic [31:0] a;
        int          d;
        bus.rd_en   = 1'b0;
        bus.wr_done = 1'b0;
        bus.hresp   = 1'b0;
        bus.rdata   = '0;
        forever begin
            if (bus.rd || bus.wr) begin
                is_wr = bus.wr;
                a     = bus.addr;
                d     = rand_dly ? int'($urandom_range(0, 5)) : 0;
                repeat (1 + d) begin
                    @(negedge clk);
                    if (bus.rd || bus.wr) viol++;
                end
                if (is_wr) begin
                    wcnt++;
                    bus.wr_done = 1'b1;
                    bus.hresp   = (wcnt == err_wr);
                end else begin
                    bus.rd_en = 1'b1;
                    bus.rdata = mdata(a);
                end
                @(negedge clk);
                bus.rd_en   = 1'b0;
                bus.wr_done = 1'b0;
                bus.hresp   = 1'b0;
                bus.rdata   = '0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic go(input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] l);
        rd_a.delete();
        wr_a.delete();
        wr_d.delete();
        ops   = '0;
        nops  = 0;
        viol  = 0;
        ndone = 0;
        wcnt  = 0;
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit spur, output int k);
        for (k = 0; k < 3000; k++) begin
            if (done) break;
            if (spur && k == 5) begin
                start    = 1'b1;
                src_addr = 32'h0BAD_0000;
                dst_addr = 32'h0BAD_1000;
                len      = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(k < 3000), 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic verify(input string t, input logic [31:0] s,
                          input logic [31:0] d, input int nr, input int nw);
        chk({t, " n_rd"}, rd_a.size(), nr);
        chk({t, " n_wr"}, wr_a.size(), nw);
        for (int i = 0; i < nr && i < rd_a.size(); i++)
            chk($sformatf("%s rd_addr%0d", t, i), rd_a[i], s + 32'(4 * i));
        for (int i = 0; i < nw && i < wr_a.size(); i++) begin
            chk($sformatf("%s wr_addr%0d", t, i), wr_a[i], d + 32'(4 * i));
            chk($sformatf("%s wr_data%0d", t, i), wr_d[i],
                mdata(s + 32'(4 * i)));
        end
        chk({t, " protocol"}, viol, 0);
        chk({t, " n_done"}, ndone, 1);
    endtask

    initial begin
        int k;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;

        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst rd", bus.rd, 0);
        chk("rst wr", bus.wr, 0);
        chk("rst addr", bus.addr, 0);
        chk("rst wdata", bus.wdata, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", busy, 0);

        // len=3, zero-wait: first rd at T+1, FIN 12 cycles later.
        go(32'h100, 32'h200, 16'd3);
        chk("l3 busy_t1", busy, 1);
        chk("l3 rd_t1", bus.rd, 1);
        chk("l3 addr_t1", bus.addr, 32'h100);
        wait_done(1'b0, k);
        chk("l3 latency", k, 12);
        verify("l3", 32'h100, 32'h200, 3, 3);
        chk("l3 order", ops, 32'h07);

        // len=10: chunks 4,4,2 with reads then writes per chunk.
        go(32'h300, 32'h200, 16'd10);
        wait_done(1'b0, k);
        verify("l10", 32'h300, 32'h200, 10, 10);
        chk("l10 order", ops, 32'h000F_0F33 >> 4);
        chk("l10 n_ops", nops, 20);
        if (wr_a.size() == 10) chk("l10 last_dst", wr_a[9], 32'h224);
        else chk("l10 last_dst_n", wr_a.size(), 10);

        // len=0: done at T+1, no requests.
        go(32'h500, 32'h600, 16'd0);
        chk("l0 busy_t1", busy, 1);
        chk("l0 done_t1", done, 1);
        chk("l0 rd_t1", bus.rd, 0);
        wait_done(1'b0, k);
        chk("l0 latency", k, 0);
        verify("l0", 32'h500, 32'h600, 0, 0);
        chk("l0 n_ops", nops, 0);

        // Address wrap, with low address bits ignored.
        go(32'hFFFF_FFFA, 32'h0000_1003, 16'd3);
        wait_done(1'b0, k);
        verify("wrap", 32'hFFFF_FFF8, 32'h0000_1000, 3, 3);
        if (rd_a.size() == 3) chk("wrap rd2", rd_a[2], 32'h0);
        else chk("wrap rd_n", rd_a.size(), 3);

        // Random response delays plus a spurious start mid-transfer.
        rand_dly = 1'b1;
        go(32'h4000, 32'h8000, 16'd9);
        wait_done(1'b1, k);
        verify("rand", 32'h4000, 32'h8000, 9, 9);
        rand_dly = 1'b0;

        // hresp on the 2nd write of a 4-word copy.
        err_wr = 2;
        go(32'h700, 32'h900, 16'd4);
        wait_done(1'b0, k);
`ifdef DMAC_SEQ_ERR_EN
        verify("herr", 32'h700, 32'h900, 4, 2);
        chk("herr err", err, 1);
        repeat (3) @(negedge clk);
        chk("herr err_sticky", err, 1);
`else
        verify("herr", 32'h700, 32'h900, 4, 4);
        chk("herr err", err, 0);
`endif
        err_wr = 0;
        go(32'hA00, 32'hB00, 16'd1);
        chk("restart err_clr", err, 0);
        wait_done(1'b0, k);
        verify("restart", 32'hA00, 32'hB00, 1, 1);
        chk("restart err", err, 0);

        // Reset mid-transfer aborts with no done pulse.
        go(32'hC00, 32'hD00, 16'd8);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort rd", bus.rd, 0);
        chk("abort wr", bus.wr, 0);
        chk("abort done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort n_done", ndone, 0);
        chk("abort idle", busy, 0);

        go(32'h40, 32'h80, 16'd2);
        wait_done(1'b0, k);
        verify("recover", 32'h40, 32'h80, 2, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
